mod_mul_vec: RTL and testbench
==============================

# mod_mul_vec

Multi-lane, fully pipelined modular multiplier for q = 3329 (ML-KEM). It adds a valid/ready handshake with backpressure and a tag sideband, plus an optional fused multiply-add/subtract against a third operand. It sits between the polynomial coefficient memories and the NTT butterfly / pointwise-multiply controllers and replaces per-lane free-running multipliers. Reduction uses the radix-16 table method: three 4-bit LUT residues plus the low 12 bits, then a 2-bit mini-reduction and a single conditional subtract.

## Interface
- LANES, default 4: number of independent coefficient lanes, 1..16.
- TAG_W, default 8: width of the opaque tag carried alongside each beat.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i && in_ready_o.
- mode_i  in  2  operation: 00 MUL, 01 MULADD, 10 MULSUB, 11 reserved (treated as MUL).
- a_i  in  LANES×12  packed coeff_t array, multiplicand.
- b_i  in  LANES×12  packed coeff_t array, multiplier.
- c_i  in  LANES×12  packed coeff_t array, addend/minuend, must be < 3329.
- tag_i  in  TAG_W  sideband returned unchanged with the result.
- out_valid_o  out  1  result beat valid.
- out_ready_i  in  1  consumer accepts when out_valid_o && out_ready_i.
- result_o  out  LANES×12  per-lane result, always in [0, 3328].
- tag_o  out  TAG_W  tag of the current result beat.

## Operation
- Per lane, stage 1 (combinational, registered into S1):
  - Form the 24-bit product p = a·b.
  - Compute s = LUT20(p[23:20]) + LUT16(p[19:16]) + LUT12(p[15:12]) + p[11:0] as 14 bits; the maximum is 13751.
- Per lane, stage 2 (combinational from S1, registered into S2/output):
  - Compute f = s[11:0] + LUT12(s[13:12]) as 13 bits.
  - r = f − 3329 if f ≥ 3329, else f.
- Results are exact mod 3329 for any 12-bit a, b, including values ≥ 3329.
- Fused operations in stage 2:
  - MULADD: t = r + c (13 bit); subtract 3329 if t ≥ 3329.
  - MULSUB: t = c − r (13 bit); add 3329 if negative.
  - c < 3329 is a precondition. c ≥ 3329 gives an unspecified result, and benches must not drive it.
- mode, c and tag travel with the beat through S1; all lanes share one valid/mode/tag.
- Handshake and stall rules:
  - s2_load = !out_valid_o || out_ready_i.
  - s1_load = !s1_valid || s2_load.
  - in_ready_o = s1_load (combinational; no path from in_valid_i).
- The two stages form an elastic pipeline. A stalled output holds result_o/tag_o stable. No beat is dropped or duplicated, and order is preserved.
- Reset:
  - Asserting rst clears s1_valid and out_valid_o asynchronously.
  - All data/tag registers reset to 0: result_o = 0, tag_o = 0.
  - in_ready_o = 1 while out of reset with an empty pipe.
  - Reset mid-operation discards all in-flight beats.

## Timing
- Latency is 2 cycles: a beat accepted at edge N is on result_o with out_valid_o = 1 after edge N+1, and consumable at edge N+2.
- Throughput is 1 beat/cycle with out_ready_i held high.
- Capacity is 2 beats. With out_ready_i low and both stages full, in_ready_o = 0.
- Simultaneous output accept and input accept on a full pipe are both allowed in the same cycle (pipe stays full).
- Critical path: 12×12 multiplier plus 4-input 14-bit adder in stage 1. Stage 2 is 2 add/compare levels (3 with MAC).

## Configuration
- POLY_MOD_MUL_MAC_EN defined: mode_i and c_i are honoured; c and mode are pipelined per lane.
- Undefined:
  - mode_i and c_i are ignored and every beat is MUL.
  - c/mode registers and the fused adder are not instantiated.
  - Ports remain present for interface stability.

## Structure
- poly_arith_pkg: existing Q and coeff_t. Add:
  - mul_mode_e enum (MUL, MULADD, MULSUB).
  - LUT12/LUT16/LUT20 residue tables as constant arrays (v·2^k mod 3329, v = 0..15).
- Sub-module mod_mul_lane: one lane's stage-1 and stage-2 datapath with S1 data register and load enables from the parent.
- The parent mod_mul_vec owns valid/ready, tag, mode, and generates LANES lanes.

## Test plan
- LANES=4, MUL, a=3328, b=3328 on all lanes -> result 1 on every lane, out_valid_o exactly 2 edges after acceptance, tag echoed.
- 8 back-to-back MUL beats, tags 0..7, out_ready_i=1 -> 8 consecutive result cycles, in order, in_ready_o never low.
- out_ready_i low for 5 cycles while driving continuously:
  - in_ready_o drops after 2 accepted beats and result_o holds stable.
  - On release, all beats drain in order with none lost or duplicated.
- a=4095, b=4095 (out of range) -> result 852. a=0, b=3328 -> 0.
- POLY_MOD_MUL_MAC_EN:
  - MULADD a=3328, b=1, c=2 -> 1.
  - MULSUB a=1, b=1, c=0 -> 3328.
  - mode 11, a=2, b=3 -> 6.
  - Without the macro, MULADD a=2, b=3, c=5 -> 6.
- rst pulsed low with 2 beats in flight -> out_valid_o 0 immediately. After release: no stale beat emerges, in_ready_o = 1, result_o = 0.

Source files
------------

// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types for ML-KEM coefficient datapaths (q = 3329):
// coefficient type, fused-operation modes and radix-16 residue tables.
package poly_arith_pkg;

    localparam logic [12:0] Q = 13'd3329;

    typedef logic [11:0] coeff_t;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULADD = 2'b01,
        MULSUB = 2'b10
    } mul_mode_e;

    typedef logic [15:0][11:0] lut_t;

    // Entry v holds v * 2^shift mod q; evaluated at elaboration only.
    function automatic lut_t build_lut(input int unsigned shift);
        lut_t lut;
        lut = '0;
        for (int unsigned v = 32'd0; v < 32'd16; v++) begin
            lut[v[3:0]] = 12'((v << shift) % 32'd3329);
        end
        return lut;
    endfunction

    localparam lut_t LUT12 = build_lut(32'd12);
    localparam lut_t LUT16 = build_lut(32'd16);
    localparam lut_t LUT20 = build_lut(32'd20);

    // The reserved encoding 2'b11 behaves as a plain multiply.
    function automatic mul_mode_e decode_mode(input logic [1:0] m);
        mul_mode_e mode;
        case (m)
            2'b01:   mode = MULADD;
            2'b10:   mode = MULSUB;
            default: mode = MUL;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/mod_mul_lane.sv
// One lane of the q = 3329 modular multiplier: product with radix-16 partial
// reduction into S1, then final fold, conditional subtract and optional MAC.
module mod_mul_lane
    import poly_arith_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      s1_en,
    input  logic      s2_en,
    input  coeff_t    a,
    input  coeff_t    b,
    input  coeff_t    c,
    input  mul_mode_e s1_mode,
    output coeff_t    result
);

    logic [23:0] prod_s;
    logic [13:0] sum_s;
    logic [13:0] s1_sum_r;
    logic [12:0] fold_s;
    coeff_t      red_s;
    coeff_t      res_s;
    coeff_t      result_r;

    // Stage 1: full product, upper nibbles folded through the residue tables
    always_comb begin
        prod_s = {12'd0, a} * {12'd0, b};
        sum_s  = {2'b00, LUT20[prod_s[23:20]]} + {2'b00, LUT16[prod_s[19:16]]}
               + {2'b00, LUT12[prod_s[15:12]]} + {2'b00, prod_s[11:0]};
    end

    // S1 partial-sum register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_sum_r <= 14'd0;
        end else if (s1_en) begin
            s1_sum_r <= sum_s;
        end
    end

    // Stage 2: fold the top two bits, then one conditional subtract (f < 2q)
    always_comb begin
        fold_s = {1'b0, s1_sum_r[11:0]} + {1'b0, LUT12[{2'b00, s1_sum_r[13:12]}]};
        if (fold_s >= Q) begin
            red_s = 12'(fold_s - Q);
        end else begin
            red_s = fold_s[11:0];
        end
    end

`ifdef POLY_MOD_MUL_MAC_EN
    coeff_t      s1_c_r;
    logic [12:0] mac_s;

    // S1 addend/minuend register travelling with the partial sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_c_r <= 12'd0;
        end else if (s1_en) begin
            s1_c_r <= c;
        end
    end

    // Fused add/subtract; both operands are already reduced so one correction suffices
    always_comb begin
        mac_s = 13'd0;
        res_s = red_s;
        case (s1_mode)
            MULADD: begin
                mac_s = {1'b0, red_s} + {1'b0, s1_c_r};
                if (mac_s >= Q) begin
                    res_s = 12'(mac_s - Q);
                end else begin
                    res_s = mac_s[11:0];
                end
            end
            MULSUB: begin
                if (s1_c_r >= red_s) begin
                    res_s = s1_c_r - red_s;
                end else begin
                    mac_s = {1'b0, s1_c_r} + Q - {1'b0, red_s};
                    res_s = mac_s[11:0];
                end
            end
            default: begin
                res_s = red_s;
            end
        endcase
    end
`else
    logic unused_s;
    assign unused_s = ^{c, s1_mode};

    // Multiply-only build: the reduced product is the result
    always_comb begin
        res_s = red_s;
    end
`endif

    // Output register, held while the consumer stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_r <= 12'd0;
        end else if (s2_en) begin
            result_r <= res_s;
        end
    end

    assign result = result_r;

endmodule

// File: rtl/mod_mul_vec.sv
// Multi-lane 2-stage elastic modular multiplier (q = 3329) with tag sideband.
// Define POLY_MOD_MUL_MAC_EN to enable fused MULADD/MULSUB against c_i.
module mod_mul_vec
    import poly_arith_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [1:0]             mode_i,
    input  coeff_t [LANES-1:0]     a_i,
    input  coeff_t [LANES-1:0]     b_i,
    input  coeff_t [LANES-1:0]     c_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output coeff_t [LANES-1:0]     result_o,
    output logic [TAG_W-1:0]       tag_o
);

    logic             s1_valid_r;
    logic             out_valid_r;
    logic [TAG_W-1:0] s1_tag_r;
    logic [TAG_W-1:0] out_tag_r;
    logic             s1_load_s;
    logic             s2_load_s;
    logic             s1_take_s;
    logic             s2_take_s;
    mul_mode_e        s1_mode_s;

    // Elastic handshake: a stage may load when it is empty or drains this cycle
    always_comb begin
        s2_load_s = !out_valid_r || out_ready_i;
        s1_load_s = !s1_valid_r || s2_load_s;
        s1_take_s = s1_load_s && in_valid_i;
        s2_take_s = s2_load_s && s1_valid_r;
    end

    // Stage valid flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (s1_load_s) begin
                s1_valid_r <= in_valid_i;
            end
            if (s2_load_s) begin
                out_valid_r <= s1_valid_r;
            end
        end
    end

    // Tag sideband follows the beat through both stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_tag_r  <= '0;
            out_tag_r <= '0;
        end else begin
            if (s1_take_s) begin
                s1_tag_r <= tag_i;
            end
            if (s2_take_s) begin
                out_tag_r <= s1_tag_r;
            end
        end
    end

`ifdef POLY_MOD_MUL_MAC_EN
    mul_mode_e s1_mode_r;

    // Operation mode captured with the beat and shared by all lanes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_mode_r <= MUL;
        end else if (s1_take_s) begin
            s1_mode_r <= decode_mode(mode_i);
        end
    end

    assign s1_mode_s = s1_mode_r;
`else
    logic unused_s;
    assign unused_s  = ^mode_i;
    assign s1_mode_s = MUL;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mod_mul_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .s1_en   (s1_take_s),
            .s2_en   (s2_take_s),
            .a       (a_i[l]),
            .b       (b_i[l]),
            .c       (c_i[l]),
            .s1_mode (s1_mode_s),
            .result  (result_o[l])
        );
    end

    assign in_ready_o  = s1_load_s;
    assign out_valid_o = out_valid_r;
    assign tag_o       = out_tag_r;

endmodule

// File: tb/tb_mod_mul_vec.sv
// Directed bench for mod_mul_vec (LANES=4): vector table plus stall, back-to-back
// and mid-flight reset sequences. Expected values are hand-computed mod 3329.
module tb_mod_mul_vec;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      mode;
    logic [3:0][11:0] a;
    logic [3:0][11:0] b;
    logic [3:0][11:0] c;
    logic [7:0]      tag;
    logic            out_valid;
    logic            out_ready;
    logic [3:0][11:0] result;
    logic [7:0]      tag_out;

    int tests = 0;
    int fails = 0;

    mod_mul_vec #(.LANES(4), .TAG_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .a_i         (a),
        .b_i         (b),
        .c_i         (c),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .tag_o       (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] c;
        logic [7:0]  tag;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [47:0] pack4(input logic [11:0] x0, input logic [11:0] x1,
                                          input logic [11:0] x2, input logic [11:0] x3);
        return {x3, x2, x1, x0};
    endfunction

    function automatic logic [47:0] rep4(input logic [11:0] x);
        return {x, x, x, x};
    endfunction

    function automatic logic [11:0] mm(input int unsigned x, input int unsigned y);
        return 12'((x * y) % 32'd3329);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [47:0] bexp[8];
        logic [47:0] sq_res[$];
        logic [7:0]  sq_tag[$];
        logic [47:0] held;
        logic [47:0] ra;
        logic [47:0] rb;
        logic [47:0] rexp;
        int seen;
        int acc;
        int rcv;

        rst = 1'b0; in_valid = 1'b0; mode = 2'b00; a = '0; b = '0; c = '0;
        tag = 8'h00; out_ready = 1'b1;

        vecs[0] = '{2'b00, rep4(12'd3328), rep4(12'd3328), rep4(12'd0), 8'hA5, rep4(12'd1)};
        vecs[1] = '{2'b00, pack4(12'd4095, 12'd0, 12'd2, 12'd1234),
                    pack4(12'd4095, 12'd3328, 12'd3, 12'd2345), rep4(12'd0), 8'h11,
                    pack4(12'd852, 12'd0, 12'd6, 12'd829)};
        vecs[2] = '{2'b00, pack4(12'd3328, 12'd17, 12'd4095, 12'd2048),
                    pack4(12'd1, 12'd1000, 12'd1, 12'd2048), rep4(12'd0), 8'h22,
                    pack4(12'd3328, 12'd355, 12'd766, 12'd3093)};
        vecs[3] = '{2'b00, pack4(12'd3329, 12'd3330, 12'd0, 12'd1),
                    pack4(12'd5, 12'd3330, 12'd0, 12'd1), rep4(12'd0), 8'h33,
                    pack4(12'd0, 12'd1, 12'd0, 12'd1)};
        vecs[4] = '{2'b11, rep4(12'd2), rep4(12'd3), rep4(12'd0), 8'h44, rep4(12'd6)};
`ifdef POLY_MOD_MUL_MAC_EN
        vecs[5] = '{2'b01, rep4(12'd3328), rep4(12'd1), rep4(12'd2), 8'h55, rep4(12'd1)};
        vecs[6] = '{2'b10, rep4(12'd1), rep4(12'd1), rep4(12'd0), 8'h66, rep4(12'd3328)};
        vecs[7] = '{2'b01, rep4(12'd2), rep4(12'd3), rep4(12'd5), 8'h77, rep4(12'd11)};
        vecs[8] = '{2'b10, rep4(12'd100), rep4(12'd10), rep4(12'd3000), 8'h88, rep4(12'd2000)};
`else
        vecs[5] = '{2'b01, rep4(12'd3328), rep4(12'd1), rep4(12'd2), 8'h55, rep4(12'd3328)};
        vecs[6] = '{2'b10, rep4(12'd1), rep4(12'd1), rep4(12'd0), 8'h66, rep4(12'd1)};
        vecs[7] = '{2'b01, rep4(12'd2), rep4(12'd3), rep4(12'd5), 8'h77, rep4(12'd6)};
        vecs[8] = '{2'b10, rep4(12'd100), rep4(12'd10), rep4(12'd3000), 8'h88, rep4(12'd1000)};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_result", 64'(result), 64'd0);
        check("reset_tag", 64'(tag_out), 64'd0);

        // Single beats from the table: exact 2-edge latency and tag echo
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = vecs[i].mode; a = vecs[i].a; b = vecs[i].b;
            c = vecs[i].c; tag = vecs[i].tag;
            #1;
            check("tv_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("tv_valid_after_1", 64'(out_valid), 64'd0);
            @(negedge clk);
            #1;
            check("tv_valid_after_2", 64'(out_valid), 64'd1);
            check("tv_result", 64'(result), 64'(vecs[i].exp));
            check("tv_tag", 64'(tag_out), 64'(vecs[i].tag));
        end
        mode = 2'b00; c = '0;
        @(negedge clk);

        // Eight back-to-back beats with the consumer always ready
        seen = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (cyc < 8) begin
                in_valid = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    a[l] = 12'(cyc * 37 + l + 10);
                    b[l] = 12'(3000 + cyc + l * 5);
                    bexp[cyc][l*12 +: 12] = mm(32'(cyc * 37 + l + 10), 32'(3000 + cyc + l * 5));
                end
                tag = 8'(cyc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc < 8) check("b2b_in_ready", 64'(in_ready), 64'd1);
            check("b2b_valid_window", 64'(out_valid), 64'((cyc >= 2 && cyc <= 9) ? 1 : 0));
            if (out_valid && seen < 8) begin
                check("b2b_result", 64'(result), 64'(bexp[seen]));
                check("b2b_tag", 64'(tag_out), 64'(seen));
                seen++;
            end
        end
        check("b2b_count", 64'(seen), 64'd8);

        // Backpressure: consumer stalls for 5 cycles while input is driven
        acc = 0; rcv = 0; held = '0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && rcv < 6; cyc++) begin
            @(negedge clk);
            if (cyc == 5) out_ready = 1'b1;
            if (acc < 6) begin
                in_valid = 1'b1;
                for (int l = 0; l < 4; l++) begin
                    ra[l*12 +: 12] = 12'(200 + acc * 11 + l);
                    rb[l*12 +: 12] = 12'(7 + acc + l * 3);
                    rexp[l*12 +: 12] = mm(32'(200 + acc * 11 + l), 32'(7 + acc + l * 3));
                end
                a = ra; b = rb; tag = 8'(20 + acc);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) held = result;
            if (cyc >= 2 && cyc <= 4) begin
                check("stall_in_ready_low", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
            end
            if (cyc == 3 || cyc == 4) check("stall_result_hold", 64'(result), 64'(held));
            if (cyc == 4) check("stall_accepted", 64'(acc), 64'd2);
            if (out_valid && out_ready) begin
                if (sq_res.size() > 0) begin
                    check("drain_result", 64'(result), 64'(sq_res.pop_front()));
                    check("drain_tag", 64'(tag_out), 64'(sq_tag.pop_front()));
                end else begin
                    check("drain_unexpected_beat", 64'(tag_out), 64'hFFFF);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                sq_res.push_back(rexp);
                sq_tag.push_back(8'(20 + acc));
                acc++;
            end
        end
        in_valid = 1'b0;
        check("drain_count", 64'(rcv), 64'd6);
        check("drain_queue_empty", 64'(sq_res.size()), 64'd0);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = rep4(12'd5); b = rep4(12'd7); tag = 8'h77;
        @(negedge clk);
        tag = 8'h78;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 64'(out_valid), 64'd1);
        check("inflight_result", 64'(result), 64'(rep4(12'd35)));
        #1;
        rst = 1'b0;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'd0);
        check("rst_async_result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            #1;
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
            check("post_rst_in_ready", 64'(in_ready), 64'd1);
            check("post_rst_result", 64'(result), 64'd0);
            check("post_rst_tag", 64'(tag_out), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
